// File: rtl/fill_responder.sv
// fill_responder: memory-side line-fill responder answering queued requests in order after a
// fixed latency. Define FILL_STORE_EN to add a 256-entry write-back line store.
module fill_responder #(
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         rqst_i,
    input  logic [19:0]  addr_i,
`ifdef FILL_STORE_EN
    input  logic         wr_en_i,
    input  logic [19:0]  wr_addr_i,
    input  logic [127:0] wr_data_i,
`endif
    output logic         full_o,
    output logic         overflow_o,
    output logic         data_ready_o,
    output logic [19:0]  addr_o,
    output logic [127:0] data_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // From IDLE the pop edge already counts toward the latency; from RESP the pop edge is
    // one cycle later relative to the previous pulse, so the next entry waits one cycle more.
    localparam logic [7:0] LoadFirst = 8'(LATENCY - 2);
    localparam logic [7:0] LoadNext  = 8'(LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // ------------------------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------------------------
    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push;
    logic            pop;
    logic            empty;
    logic            overflow_q;

    assign full_o     = (count_q == CntW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = rqst_i && !full_o;
    assign overflow_o = overflow_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (rqst_i && full_o) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= addr_i[19:4];
        end
    end

    // ------------------------------------------------------------------------------------
    // Response sequencer
    // ------------------------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [15:0]  line_q, line_d;
    logic         load_resp;
    logic [127:0] resp_data;
    logic [19:0]  addr_q;
    logic [127:0] data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        pop       = 1'b0;
        load_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    line_d  = fifo_mem[rd_ptr_q];
                    cnt_d   = LoadFirst;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 8'd0) begin
                    load_resp = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (!empty) begin
                    pop     = 1'b1;
                    line_d  = fifo_mem[rd_ptr_q];
                    cnt_d   = LoadNext;
                    state_d = StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            line_q  <= 16'd0;
            addr_q  <= 20'd0;
            data_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            if (load_resp) begin
                addr_q <= {line_q, 4'b0000};
                data_q <= resp_data;
            end
        end
    end

    assign data_ready_o = (state_q == StResp);
    assign addr_o       = addr_q;
    assign data_o       = data_q;

    // Word w of line L is {14'b0, L, w[1:0]}.
    function automatic logic [127:0] default_line(input logic [15:0] line);
        logic [127:0] d;
        d = '0;
        for (int w = 0; w < 4; w++) begin
            d[w*32 +: 32] = {14'b0, line, 2'(w)};
        end
        return d;
    endfunction

    // ------------------------------------------------------------------------------------
    // Optional line store
    // ------------------------------------------------------------------------------------
`ifdef FILL_STORE_EN
    logic [127:0] store_data [256];
    logic [7:0]   store_tag  [256];
    logic [255:0] store_valid_q;
    logic [7:0]   rd_idx;
    logic [7:0]   wr_idx;
    logic         unused_low;

    assign rd_idx     = line_q[7:0];
    assign wr_idx     = wr_addr_i[11:4];
    assign unused_low = ^{addr_i[3:0], wr_addr_i[3:0]};

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            store_valid_q <= '0;
        end else if (wr_en_i) begin
            store_valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            store_data[wr_idx] <= wr_data_i;
            store_tag[wr_idx]  <= wr_addr_i[19:12];
        end
    end

    always_comb begin
        resp_data = default_line(line_q);
        if (store_valid_q[rd_idx] && (store_tag[rd_idx] == line_q[15:8])) begin
            resp_data = store_data[rd_idx];
        end
        // A write landing on the same edge that loads the response has not reached the store.
        if (wr_en_i && (wr_addr_i[19:4] == line_q)) begin
            resp_data = wr_data_i;
        end
    end
`else
    logic unused_low;

    assign unused_low = ^addr_i[3:0];

    always_comb begin
        resp_data = default_line(line_q);
    end
`endif

endmodule
